seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.

---
 rtl/seq_restoring_divider.sv | 138 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: a 2N-bit dividend divided by an
// N-bit divisor gives an N-bit quotient and an N-bit remainder, one quotient
// bit per clock. Valid/ready handshake on both sides, one division in flight.
module seq_restoring_divider #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_zero,
   output logic           overflow
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [N-1:0]    r_q;
   logic [N-1:0]    q_q;
   logic [N-1:0]    divisor_q;
   logic [CW-1:0]   cnt_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [N-1:0]    quotient_q;
   logic [N-1:0]    remainder_q;
   logic            div_zero_q;
   logic            overflow_q;

   logic [N:0]      trial;
   logic [N-1:0]    diff_lo;
   logic            borrow_lo;
   logic            borrow;
   logic [N-1:0]    r_d;
   logic [N-1:0]    q_d;

   // One restoring step. The partial remainder is always below the divisor,
   // so it is held in N bits; the shifted-in top bit only matters for the
   // borrow (if it is set the trial value exceeds any divisor), and the
   // N-bit difference is then exact modulo 2^N.
   always_comb begin
      trial                = {r_q, q_q[N-1]};
      {borrow_lo, diff_lo} = {1'b0, trial[N-1:0]} - {1'b0, divisor_q};
      borrow               = borrow_lo & ~trial[N];
      r_d                  = borrow ? trial[N-1:0] : diff_lo;
      q_d                  = {q_q[N-2:0], ~borrow};
   end

   // Control FSM, working registers and registered handshake/result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         q_q         <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (divisor == '0) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= dividend[N-1:0];
                     div_zero_q  <= 1'b1;
                     overflow_q  <= 1'b0;
                  end else if (dividend[2*N-1:N] >= divisor) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     div_zero_q  <= 1'b0;
                     overflow_q  <= 1'b1;
                  end else begin
                     state_q    <= S_CALC;
                     r_q        <= dividend[2*N-1:N];
                     q_q        <= dividend[N-1:0];
                     divisor_q  <= divisor;
                     cnt_q      <= CW'(N - 1);
                     div_zero_q <= 1'b0;
                     overflow_q <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  quotient_q  <= q_d;
                  remainder_q <= r_d;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (N=16): the driver pushes the
// expected result when an operand is accepted, and a monitor compares every
// cycle the DUT presents a result, popping it when the result is taken.
module tb_seq_restoring_divider;

   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [2*N-1:0] dividend = '0;
   logic [N-1:0]   divisor = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           div_zero;
   logic           overflow;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      logic         ov;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rmode = 0;   // 0: always ready, 1: random stalls, 2: held off

   seq_restoring_divider #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
   endtask

   // Consumer side: out_ready changes just after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3, 0) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares presented results against the scoreboard head.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            chk("in_ready_low_while_valid", in_ready, 0);
            if (sb.size() == 0) begin
               fail_now("unexpected_result");
            end else begin
               if (!prev) chk("latency", cyc - sb[0].acc, sb[0].lat);
               chk("quotient", quotient, sb[0].q);
               chk("remainder", remainder, sb[0].r);
               chk("div_zero", div_zero, sb[0].dz);
               chk("overflow", overflow, sb[0].ov);
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev = out_valid;
      end
   end

   // Present operands, wait (bounded) for acceptance, record the expectation.
   task automatic send(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                       input logic [N-1:0] q, input logic [N-1:0] r,
                       input logic dz, input logic ov);
      exp_t e;
      int   t;
      t = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(negedge clk);
      while (!in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         fail_now("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.ov  = ov;
      e.lat = (dz || ov) ? 0 : N;
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = N'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         fail_now("drain_timeout");
         sb.delete();
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      logic [N-1:0]   x, y, r;
      logic [2*N-1:0] p;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_zero", div_zero, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;

      // Directed vectors
      rmode = 0;
      send(32'd100000,     16'd7,      16'd14285, 16'd5,      1'b0, 1'b0);
      send(32'hFFFE_0001,  16'hFFFF,   16'hFFFF,  16'd0,      1'b0, 1'b0);
      send(32'h0007_0000,  16'd7,      16'hFFFF,  16'd0,      1'b0, 1'b1);
      send(32'h1234_5678,  16'd0,      16'hFFFF,  16'h5678,   1'b1, 1'b0);
      send(32'd0,          16'd5,      16'd0,     16'd0,      1'b0, 1'b0);
      send(32'h0000_FFFF,  16'd1,      16'hFFFF,  16'd0,      1'b0, 1'b0);
      send(32'h0001_0000,  16'd2,      16'h8000,  16'd0,      1'b0, 1'b0);
      send(32'd1000,       16'd1001,   16'd0,     16'd1000,   1'b0, 1'b0);
      send(32'h0003_0000,  16'd3,      16'hFFFF,  16'd0,      1'b0, 1'b1);
      send(32'h0002_FFFF,  16'd3,      16'hFFFF,  16'd2,      1'b0, 1'b0);
      send(32'h0000_0000,  16'd0,      16'hFFFF,  16'd0,      1'b1, 1'b0);
      drain();

      // Backpressure: result held 5 cycles while new operands are offered
      rmode = 2;
      send(32'd50000, 16'd9, 16'd5555, 16'd5, 1'b0, 1'b0);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) fail_now("bp_valid_timeout");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         dividend = 32'h0000_0010;
         divisor  = 16'd1;
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid_held", out_valid, 1);
      end
      in_valid = 1'b0;
      rmode    = 0;
      t = 0;
      @(negedge clk);
      while (out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("bp_take_out_valid", out_valid, 0);
      chk("bp_take_in_ready", in_ready, 1);
      drain();

      // Asynchronous reset in the middle of a calculation
      send(32'd100000, 16'd7, 16'd14285, 16'd5, 1'b0, 1'b0);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_quotient", quotient, 0);
      chk("arst_remainder", remainder, 0);
      chk("arst_flags", {div_zero, overflow}, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send(32'd1234567, 16'd1000, 16'd1234, 16'd567, 1'b0, 1'b0);
      drain();

      // Closed loop: dividend built as x*y + r, so quotient=x, remainder=r
      rmode = 1;
      for (int i = 0; i < 1000; i++) begin
         x = N'($urandom);
         y = N'($urandom_range(65535, 1));
         r = N'($urandom_range(int'(y) - 1, 0));
         p = x * y;
         send(p + {16'd0, r}, y, x, r, 1'b0, 1'b0);
      end
      drain();
      rmode = 0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
